result_page_sequencer: RTL

//  Sequences the 400-bit recognition result (result/done from the camera pipeline) onto the LCD1602 character writer.

---
 rtl/arm_disp_pkg.sv | 22 ++
 rtl/result_page_sequencer_key_debounce.sv | 42 ++++
 rtl/result_page_sequencer.sv | 108 ++++++++++
 3 files changed

// File: rtl/arm_disp_pkg.sv
// Shared constants, FSM state type and byte-select helpers for the result page sequencer.
package arm_disp_pkg;
   localparam int RESULT_W   = 400;
   localparam int NUM_BYTES  = RESULT_W / 8;
   localparam int PAGE_BYTES = 32;
   localparam int NUM_PAGES  = (NUM_BYTES + PAGE_BYTES - 1) / PAGE_BYTES;
   localparam logic [7:0] CHR_SPACE = 8'h20;

   typedef enum logic [1:0] {IDLE, LOAD, NEXT, STREAM} state_t;

   function automatic logic [5:0] glob_idx(input logic pg, input logic [4:0] k);
      glob_idx = 6'(int'(pg) * PAGE_BYTES + int'(k));
   endfunction

   // Byte 0 sits in the MSBs; indices past the result read as blanks.
   function automatic logic [7:0] byte_sel(input logic [RESULT_W-1:0] v, input logic [5:0] g);
      logic [RESULT_W-1:0] sh;
      sh = v << {g, 3'b000};
      if (int'(g) >= NUM_BYTES) byte_sel = CHR_SPACE;
      else                      byte_sel = sh[RESULT_W-1 -: 8];
   endfunction
endpackage

// File: rtl/result_page_sequencer_key_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter, one-cycle pulse on press (1->0).
module key_debounce #(
   parameter int DEBOUNCE_CYC = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic key_in,
   output logic press
);
   localparam int CW = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);

   logic [1:0]    sync_q;
   logic          level;
   logic [CW-1:0] cnt;
   logic          sync;

   assign sync = sync_q[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= 2'b11;
         level  <= 1'b1;
         cnt    <= '0;
         press  <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], key_in};
         press  <= 1'b0;
         if (sync != level) begin
            if (cnt == LAST) begin
               level <= sync;
               cnt   <= '0;
               press <= ~sync;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end
endmodule

// File: rtl/result_page_sequencer.sv
// Snapshots the recognition result on done rising edge and streams 32-char LCD pages over valid/ready.
module result_page_sequencer
   import arm_disp_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 1_000_000
) (
   input  logic                sys_clk,
   input  logic                sys_rst,
   input  logic                done,
   input  logic [RESULT_W-1:0] result,
   input  logic                key_in,
   output logic                chr_valid,
   input  logic                chr_ready,
   output logic [7:0]          chr_data,
   output logic [4:0]          chr_pos,
   output logic                page_idx,
   output logic                busy,
   output logic [7:0]          drop_cnt
);
   localparam logic [4:0] LAST_K = 5'(PAGE_BYTES - 1);

   state_t              state;
   logic                done_q;
   logic                done_rise;
   logic                key_press;
   logic                res_pend;
   logic                key_pend;
   logic [RESULT_W-1:0] shadow;
   logic [RESULT_W-1:0] active;
   logic                next_page;

   assign done_rise = done & ~done_q;
   assign next_page = (int'(page_idx) == NUM_PAGES - 1) ? 1'b0 : page_idx + 1'b1;

   key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key (
      .clk    (sys_clk),
      .rst    (sys_rst),
      .key_in (key_in),
      .press  (key_press)
   );

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state     <= IDLE;
         done_q    <= 1'b0;
         res_pend  <= 1'b0;
         key_pend  <= 1'b0;
         shadow    <= '0;
         active    <= '0;
         page_idx  <= 1'b0;
         chr_valid <= 1'b0;
         chr_data  <= 8'h00;
         chr_pos   <= '0;
         busy      <= 1'b0;
         drop_cnt  <= '0;
      end else begin
         done_q <= done;
         if (done_rise) shadow <= result;
         // A pending snapshot being moved to active this cycle is not a drop.
         if (done_rise && res_pend && state != LOAD && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 1'b1;

         case (state)
            IDLE: begin
               if (res_pend)      state <= LOAD;
               else if (key_pend) state <= NEXT;
            end
            LOAD: begin
               active    <= shadow;
               res_pend  <= 1'b0;
               key_pend  <= 1'b0;
               page_idx  <= 1'b0;
               chr_pos   <= '0;
               chr_data  <= byte_sel(shadow, glob_idx(1'b0, 5'd0));
               chr_valid <= 1'b1;
               busy      <= 1'b1;
               state     <= STREAM;
            end
            NEXT: begin
               page_idx  <= next_page;
               key_pend  <= 1'b0;
               chr_pos   <= '0;
               chr_data  <= byte_sel(active, glob_idx(next_page, 5'd0));
               chr_valid <= 1'b1;
               busy      <= 1'b1;
               state     <= STREAM;
            end
            STREAM: begin
               if (chr_ready) begin
                  if (chr_pos == LAST_K) begin
                     chr_valid <= 1'b0;
                     busy      <= 1'b0;
                     state     <= IDLE;
                  end else begin
                     chr_pos  <= chr_pos + 1'b1;
                     chr_data <= byte_sel(active, glob_idx(page_idx, chr_pos + 1'b1));
                  end
               end
            end
            default: state <= IDLE;
         endcase

         // New events win over same-cycle clears so nothing is lost.
         if (done_rise) res_pend <= 1'b1;
         if (key_press) key_pend <= 1'b1;
      end
   end
endmodule
